// File: rtl/connect4_turn_controller_if.sv
// Bus between the turn controller and the Connect-4 column datapath.
// The controller drives the move command and clear pulse; the datapath and
// win detector return their status.
interface connect4_turn_controller_if;
  logic [1:0] state;
  logic [6:0] in_column;
  logic       board_clear;
  logic       invalid_column;
  logic       win_in;

  modport master (
    output state,
    output in_column,
    output board_clear,
    input  invalid_column,
    input  win_in
  );

  modport slave (
    input  state,
    input  in_column,
    input  board_clear,
    output invalid_column,
    output win_in
  );
endinterface

// File: rtl/connect4_turn_controller.sv
// Turn sequencer for Connect-4: latches a column, issues one-cycle move commands,
// evaluates the datapath/win response, and tracks turns, timeouts and game result.
module connect4_turn_controller #(
  parameter int unsigned TURN_TIMEOUT  = 1000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [6:0]                        col_sel,
  input  logic                              drop,
  connect4_turn_controller_if.master        dp,
  output logic                              current_player,
  output logic [5:0]                        move_count,
  output logic [1:0]                        winner,
  output logic                              game_over,
  output logic                              invalid_move,
  output logic                              turn_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StCommit,
    StWait,
    StGameOver
  } fsm_e;

  localparam logic [15:0] TimerLast  = 16'(TURN_TIMEOUT - 1);
  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0]  MaxMoves   = 6'd42;

  fsm_e        fsm_q, fsm_d;
  logic [1:0]  state_q, state_d;
  logic [6:0]  in_column_q, in_column_d;
  logic        player_q, player_d;
  logic [5:0]  move_count_q, move_count_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_over_q, game_over_d;
  logic        invalid_move_q, invalid_move_d;
  logic        turn_timeout_q, turn_timeout_d;
  logic        board_clear_q, board_clear_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  settle_q, settle_d;

  logic        col_onehot;
  logic [6:0]  col_next;
  logic [5:0]  move_inc;

  assign col_onehot = (col_sel != 7'd0) && ((col_sel & (col_sel - 7'd1)) == 7'd0);
  assign col_next   = col_onehot ? col_sel : in_column_q;
  assign move_inc   = move_count_q + 6'd1;

  always_comb begin
    fsm_d          = fsm_q;
    state_d        = 2'b00;
    in_column_d    = in_column_q;
    player_d       = player_q;
    move_count_d   = move_count_q;
    winner_d       = winner_q;
    game_over_d    = game_over_q;
    invalid_move_d = 1'b0;
    turn_timeout_d = 1'b0;
    board_clear_d  = 1'b0;
    // Timer only runs in SELECT, so leaving any other state enters SELECT at zero.
    timer_d        = 16'd0;
    settle_d       = 4'd0;

    unique case (fsm_q)
      StIdle, StGameOver: begin
        if (start) begin
          fsm_d         = StSelect;
          board_clear_d = 1'b1;
          player_d      = 1'b0;
          move_count_d  = 6'd0;
          winner_d      = 2'b00;
          game_over_d   = 1'b0;
          in_column_d   = 7'd0;
        end
      end

      StSelect: begin
        timer_d     = timer_q + 16'd1;
        in_column_d = col_next;
        if (drop && (col_next != 7'd0)) begin
          fsm_d   = StCommit;
          state_d = {player_q, ~player_q};
          timer_d = 16'd0;
        end else if (timer_q == TimerLast) begin
          turn_timeout_d = 1'b1;
          player_d       = ~player_q;
          in_column_d    = 7'd0;
          timer_d        = 16'd0;
        end
      end

      StCommit: begin
        fsm_d = StWait;
      end

      StWait: begin
        if (settle_q == SettleLast) begin
          if (dp.invalid_column) begin
            fsm_d          = StSelect;
            invalid_move_d = 1'b1;
          end else if (dp.win_in) begin
            fsm_d        = StGameOver;
            move_count_d = move_inc;
            winner_d     = {player_q, ~player_q};
            game_over_d  = 1'b1;
          end else if (move_inc == MaxMoves) begin
            fsm_d        = StGameOver;
            move_count_d = move_inc;
            winner_d     = 2'b11;
            game_over_d  = 1'b1;
          end else begin
            fsm_d        = StSelect;
            move_count_d = move_inc;
            player_d     = ~player_q;
            in_column_d  = 7'd0;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q          <= StIdle;
      state_q        <= 2'b00;
      in_column_q    <= 7'd0;
      player_q       <= 1'b0;
      move_count_q   <= 6'd0;
      winner_q       <= 2'b00;
      game_over_q    <= 1'b0;
      invalid_move_q <= 1'b0;
      turn_timeout_q <= 1'b0;
      board_clear_q  <= 1'b0;
      timer_q        <= 16'd0;
      settle_q       <= 4'd0;
    end else begin
      fsm_q          <= fsm_d;
      state_q        <= state_d;
      in_column_q    <= in_column_d;
      player_q       <= player_d;
      move_count_q   <= move_count_d;
      winner_q       <= winner_d;
      game_over_q    <= game_over_d;
      invalid_move_q <= invalid_move_d;
      turn_timeout_q <= turn_timeout_d;
      board_clear_q  <= board_clear_d;
      timer_q        <= timer_d;
      settle_q       <= settle_d;
    end
  end

  assign dp.state       = state_q;
  assign dp.in_column   = in_column_q;
  assign dp.board_clear = board_clear_q;
  assign current_player = player_q;
  assign move_count     = move_count_q;
  assign winner         = winner_q;
  assign game_over      = game_over_q;
  assign invalid_move   = invalid_move_q;
  assign turn_timeout   = turn_timeout_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller: a per-cycle vector table plus
// hand-written sequences for win, draw, timeout-vs-drop and mid-move reset.
module tb_connect4_turn_controller;

  localparam int TO     = 8;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] col_sel;
  logic       drop;
  logic       current_player;
  logic [5:0] move_count;
  logic [1:0] winner;
  logic       game_over;
  logic       invalid_move;
  logic       turn_timeout;

  connect4_turn_controller_if dp_if ();

  connect4_turn_controller #(
    .TURN_TIMEOUT (TO),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .col_sel       (col_sel),
    .drop          (drop),
    .dp            (dp_if),
    .current_player(current_player),
    .move_count    (move_count),
    .winner        (winner),
    .game_over     (game_over),
    .invalid_move  (invalid_move),
    .turn_timeout  (turn_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [6:0]  col;
    logic        drop;
    logic        inv;
    logic        win;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[64];
  int   ntbl = 0;
  int   nvec = 0;
  int   nerr = 0;

  // Bench model for the hand-written sequences.
  logic       m_player;
  int         m_mc;
  logic [1:0] m_winner;
  logic       m_go;

  // {state, in_column, player, move_count, winner, game_over, invalid, timeout, clear}
  function automatic logic [21:0] ex(input int st, input int ic, input int pl, input int mc,
                                     input int wn, input int go, input int iv, input int tmo,
                                     input int bc);
    return {2'(st), 7'(ic), 1'(pl), 6'(mc), 2'(wn), 1'(go), 1'(iv), 1'(tmo), 1'(bc)};
  endfunction

  function automatic logic [21:0] outs();
    return {dp_if.state, dp_if.in_column, current_player, move_count, winner, game_over,
            invalid_move, turn_timeout, dp_if.board_clear};
  endfunction

  task automatic add(input int s, input int c, input int d, input int iv, input int w,
                     input logic [21:0] e);
    tbl[ntbl].start = 1'(s);
    tbl[ntbl].col   = 7'(c);
    tbl[ntbl].drop  = 1'(d);
    tbl[ntbl].inv   = 1'(iv);
    tbl[ntbl].win   = 1'(w);
    tbl[ntbl].exp   = e;
    ntbl++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("start_outputs", 32'(outs()), 32'(ex(0, 0, 0, 0, 0, 0, 0, 0, 1)));
    @(negedge clk);
    start    = 1'b0;
    m_player = 1'b0;
    m_mc     = 0;
    m_winner = 2'b00;
    m_go     = 1'b0;
  endtask

  task automatic do_move(input logic [6:0] col, input logic inv, input logic win);
    logic [6:0] exp_col;
    @(negedge clk);
    col_sel = col;
    drop    = 1'b1;
    @(posedge clk);
    #1;
    check("commit_state", 32'(dp_if.state), m_player ? 32'd2 : 32'd1);
    check("commit_column", 32'(dp_if.in_column), 32'(col));
    check("commit_no_timeout", 32'(turn_timeout), 32'd0);
    @(negedge clk);
    drop    = 1'b0;
    col_sel = (col == 7'd1) ? 7'd2 : 7'd1;  // must not disturb the frozen column
    for (int i = 0; i < SETTLE; i++) begin
      @(posedge clk);
      #1;
      check("wait_state_idle", 32'(dp_if.state), 32'd0);
      @(negedge clk);
    end
    invalid_column_drive(inv, win);
    @(posedge clk);
    #1;
    exp_col = col;
    if (!inv) begin
      m_mc++;
      if (win) begin
        m_winner = {m_player, ~m_player};
        m_go     = 1'b1;
      end else if (m_mc == 42) begin
        m_winner = 2'b11;
        m_go     = 1'b1;
      end else begin
        m_player = ~m_player;
        exp_col  = 7'd0;
      end
    end
    check("result_move_count", 32'(move_count), 32'(m_mc));
    check("result_player", 32'(current_player), 32'(m_player));
    check("result_winner", 32'(winner), 32'(m_winner));
    check("result_game_over", 32'(game_over), 32'(m_go));
    check("result_invalid_move", 32'(invalid_move), 32'(inv));
    check("result_in_column", 32'(dp_if.in_column), 32'(exp_col));
    @(negedge clk);
    invalid_column_drive(1'b0, 1'b0);
    col_sel = 7'd0;
  endtask

  task automatic invalid_column_drive(input logic inv, input logic win);
    dp_if.invalid_column = inv;
    dp_if.win_in         = win;
  endtask

  initial begin
    // Vector table: inputs driven before each edge, outputs expected after it.
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));     // start
    add(0, 1, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));     // latch col 1
    add(0, 0, 1, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0));     // P1 commit
    add(0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 0, 0, 0));     // accepted
    add(0, 2, 1, 0, 0, ex(2, 2, 1, 1, 0, 0, 0, 0, 0));     // P2 commit
    add(0, 0, 0, 0, 0, ex(0, 2, 1, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 2, 1, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, 0, ex(0, 2, 1, 1, 0, 0, 1, 0, 0));     // rejected
    add(0, 0, 0, 0, 0, ex(0, 2, 1, 1, 0, 0, 0, 0, 0));
    add(0, 4, 1, 0, 0, ex(2, 4, 1, 1, 0, 0, 0, 0, 0));     // P2 retries
    add(0, 0, 0, 0, 0, ex(0, 4, 1, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 4, 1, 1, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 0, 0, 0, 0));
    add(0, 5, 0, 0, 0, ex(0, 0, 0, 2, 0, 0, 0, 0, 0));     // multi-hot ignored
    add(0, 0, 1, 0, 0, ex(0, 0, 0, 2, 0, 0, 0, 0, 0));     // drop with no column
    add(0, 5, 1, 0, 0, ex(0, 0, 0, 2, 0, 0, 0, 0, 0));
    add(0, 64, 1, 0, 0, ex(1, 64, 0, 2, 0, 0, 0, 0, 0));   // same-cycle select+drop
    add(0, 0, 0, 0, 0, ex(0, 64, 0, 2, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 64, 0, 2, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, ex(0, 64, 0, 3, 1, 1, 0, 0, 0));    // P1 wins
    add(0, 1, 1, 0, 0, ex(0, 64, 0, 3, 1, 1, 0, 0, 0));    // drop ignored
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1));     // new game
    for (int i = 0; i < TO - 1; i++) add(0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 0, 1, 0));     // timeout
    add(1, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 0, 0, 0));     // start ignored in SELECT

    reset                = 1'b0;
    start                = 1'b0;
    col_sel              = 7'd0;
    drop                 = 1'b0;
    dp_if.invalid_column = 1'b0;
    dp_if.win_in         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      start                = tbl[i].start;
      col_sel              = tbl[i].col;
      drop                 = tbl[i].drop;
      dp_if.invalid_column = tbl[i].inv;
      dp_if.win_in         = tbl[i].win;
      @(posedge clk);
      #1;
      check($sformatf("vector_%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    @(negedge clk);
    start                = 1'b0;
    col_sel              = 7'd0;
    drop                 = 1'b0;
    dp_if.invalid_column = 1'b0;
    dp_if.win_in         = 1'b0;

    // P2 to move after the timeout; P2 wins.
    m_player = 1'b1;
    m_mc     = 0;
    m_winner = 2'b00;
    m_go     = 1'b0;
    do_move(7'b0001000, 1'b0, 1'b1);
    @(negedge clk);
    col_sel = 7'd1;
    drop    = 1'b1;
    @(posedge clk);
    #1;
    check("game_over_drop_ignored", 32'(outs()), 32'(ex(0, 8, 1, 1, 2, 1, 0, 0, 0)));
    @(negedge clk);
    col_sel = 7'd0;
    drop    = 1'b0;
    do_start();

    // Full board without a winner ends in a draw.
    for (int i = 0; i < 42; i++) do_move(7'(1 << (i % 7)), 1'b0, 1'b0);
    check("draw_winner", 32'(winner), 32'd3);
    check("draw_move_count", 32'(move_count), 32'd42);

    // Drop accepted in the expiry cycle beats the timeout.
    do_start();
    repeat (TO - 1) @(posedge clk);
    do_move(7'b0010000, 1'b0, 1'b0);

    // Reset in the middle of a move.
    @(negedge clk);
    col_sel = 7'b0000010;
    drop    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    col_sel = 7'd0;
    drop    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midmove_reset_outputs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    col_sel = 7'd1;
    drop    = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 32'(outs()), 32'd0);
    @(negedge clk);
    col_sel = 7'd0;
    drop    = 1'b0;
    do_start();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/connect4_turn_controller.md
# connect4_turn_controller

Sequences play on the Connect-4 column datapath (`ColumnsCircuit`). It latches a one-hot column selection from the player inputs and issues one-cycle move commands to the datapath. It then evaluates the datapath's `invalid_column` response and the external win detector, alternates turns, enforces a per-turn timeout, and tracks move count, winner, draw and game-over.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 1000: cycles a player may idle in SELECT before forfeiting the turn; legal range 2..65535.
- `SETTLE_CYCLES`, default 2: cycles waited after a commit before sampling datapath and win inputs; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a new game from IDLE or GAME_OVER.
- `col_sel`  in  7  column request, one-hot; bit 0 = column 1.
- `drop`  in  1  single-cycle pulse; commit the latched column.
- `invalid_column`  in  1  from datapath; target column full or illegal.
- `win_in`  in  1  from win detector; the player who just moved has four in a row.
- `state`  out  2  to datapath `state`: 00 idle, 01 P1 move, 10 P2 move; 11 never driven.
- `in_column`  out  7  to datapath `in_column`; the latched one-hot column.
- `current_player`  out  1  0 = P1, 1 = P2.
- `move_count`  out  6  accepted moves this game, 0..42.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw.
- `game_over`  out  1  high while in GAME_OVER.
- `invalid_move`  out  1  one-cycle pulse; move rejected by the datapath.
- `turn_timeout`  out  1  one-cycle pulse; turn forfeited.
- `board_clear`  out  1  one-cycle pulse on `start`; the top level uses it to clear the datapath.

## Operation
- FSM states: IDLE, SELECT, COMMIT, WAIT, GAME_OVER.
- IDLE:
  - `start` -> SELECT with `current_player`=0 and `move_count`=0.
  - `board_clear` pulses in the same cycle `start` is sampled.
- SELECT:
  - Any cycle with `col_sel` exactly one-hot latches it into `in_column`.
  - Zero-hot or multi-hot `col_sel` is ignored; `in_column` is kept.
  - `drop` with `in_column`≠0 -> COMMIT.
  - `drop` with `in_column`=0 is ignored.
  - If `drop` and a new one-hot `col_sel` arrive in the same cycle, the new column is used.
- COMMIT (exactly 1 cycle):
  - `state` = 01 if `current_player`=0, else 10.
  - -> WAIT.
  - `in_column` is frozen from COMMIT until the next SELECT.
- WAIT (exactly `SETTLE_CYCLES` cycles):
  - `state`=00.
  - On the last cycle, sample `invalid_column`, then `win_in`, in that priority:
    - `invalid_column`=1: pulse `invalid_move`, -> SELECT, same player, `move_count` unchanged.
    - else `win_in`=1: increment `move_count`; `winner` = 01 or 10 for the mover; -> GAME_OVER.
    - else, if the incremented `move_count` = 42: `winner`=11; -> GAME_OVER.
    - else increment `move_count`, toggle `current_player`, clear `in_column` to 0, -> SELECT.
- Turn timer (16-bit):
  - Clears on every entry to SELECT.
  - Counts while in SELECT.
  - At count `TURN_TIMEOUT`-1 without an accepted `drop`:
    - pulse `turn_timeout`, toggle `current_player`, clear `in_column`, restart the timer, stay in SELECT.
    - `move_count` unchanged.
  - `drop` accepted in the same cycle as expiry: the drop wins and no timeout occurs.
- GAME_OVER:
  - All outputs held; `col_sel` and `drop` ignored.
  - `start` -> SELECT with P1, `move_count`=0, `winner`=00; pulse `board_clear`.
- `start` in SELECT, COMMIT or WAIT is ignored.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - FSM=IDLE, `state`=00, `in_column`=0, `current_player`=0.
  - `move_count`=0, `winner`=00, `game_over`=0.
  - all pulse outputs 0, timer=0.
- All outputs are registered; no combinational input-to-output paths.
- Latency from a sampled `drop` to `state`≠00: 1 cycle. `state` is nonzero for exactly 1 cycle per move.
- Result timing: the result (pulse, counter update, FSM change) takes effect `SETTLE_CYCLES` cycles after the COMMIT cycle.
- Move throughput: at most one move per `SETTLE_CYCLES`+2 cycles.
- `game_over` rises in the cycle after the deciding WAIT sample; `winner` updates in the same edge.
- Reset asserted mid-move (COMMIT or WAIT):
  - immediate return to IDLE with `state`=00, no partial update.
  - after release, the block waits for `start`.

## Test plan
- Reset, `start`, P1 selects `col_sel`=0000001 and drops:
  - `state`=01 for one cycle with `in_column`=0000001.
  - after settle: `move_count`=1, `current_player`=1.
- P2 drops while the datapath drives `invalid_column`=1:
  - `invalid_move` pulses once, `current_player` stays 1, `move_count` unchanged.
  - next valid drop issues `state`=10.
- `col_sel`=0000101 (multi-hot) then `drop` with `in_column`=0: no COMMIT, `state` stays 00.
- `TURN_TIMEOUT`=8, P1 idle for 8 cycles in SELECT:
  - `turn_timeout` pulses, `current_player`=1, `move_count`=0.
- `win_in`=1 sampled after P2's move:
  - `winner`=10, `game_over`=1, later drops ignored.
  - `start` gives `board_clear` pulse, `winner`=00, `current_player`=0.
- 42 accepted moves with `win_in`=0: `winner`=11, `game_over`=1.
- `reset` asserted during WAIT: `state`=00 and `move_count`=0 immediately, FSM in IDLE.
